// File: rtl/l2_cpu_req_queue.sv
// Decoupling queue in front of the L2 core: a first-word-fall-through request FIFO plus a
// single flush slot that is released to the L2 only after every older request has drained.
module l2_cpu_req_queue #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 32,
    parameter int WORD_BITS = 64
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         req_in_valid,
    output logic                         req_in_ready,
    input  logic [1:0]                   req_in_cpu_msg,
    input  logic [2:0]                   req_in_hsize,
    input  logic                         req_in_hprot,
    input  logic [ADDR_BITS-1:0]         req_in_addr,
    input  logic [WORD_BITS-1:0]         req_in_word,
    input  logic [5:0]                   req_in_amo,

    output logic                         req_out_valid,
    input  logic                         req_out_ready,
    output logic [1:0]                   req_out_cpu_msg,
    output logic [2:0]                   req_out_hsize,
    output logic                         req_out_hprot,
    output logic [ADDR_BITS-1:0]         req_out_addr,
    output logic [WORD_BITS-1:0]         req_out_word,
    output logic [5:0]                   req_out_amo,

    input  logic                         flush_in_valid,
    output logic                         flush_in_ready,
    input  logic                         flush_in_i,
    output logic                         flush_out_valid,
    input  logic                         flush_out_ready,
    output logic                         flush_out_i,

    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + 3 + 1 + ADDR_BITS + WORD_BITS + 6;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } flush_state_t;

    // Flush FSM state is kept as a named signal so checkers can bind to it directly.
    flush_state_t flush_state;
    flush_state_t flush_next;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               flush_type;
    logic               flush_capture;
    logic               flush_pending;
    logic               push;
    logic               pop;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and ready here depends on registered state only.
    assign flush_pending = (flush_state == PEND);
    assign req_in_ready  = (count != CNT_W'(DEPTH)) && !flush_pending;
    assign req_out_valid = (count != '0);
    assign push          = req_in_valid && req_in_ready;
    assign pop           = req_out_valid && req_out_ready;
    assign flush_out_i   = flush_type;

    assign {req_out_cpu_msg, req_out_hsize, req_out_hprot,
            req_out_addr, req_out_word, req_out_amo} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_in_cpu_msg, req_in_hsize, req_in_hprot,
                            req_in_addr, req_in_word, req_in_amo};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            flush_state <= IDLE;
            flush_type  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            flush_state <= flush_next;
            if (flush_capture) flush_type <= flush_in_i;
        end
    end

    // A push accepted alongside a flush capture is older, so it drains before the flush shows.
    always_comb begin
        flush_next      = flush_state;
        flush_in_ready  = 1'b0;
        flush_out_valid = 1'b0;
        flush_capture   = 1'b0;
        case (flush_state)
            IDLE: begin
                flush_in_ready = 1'b1;
                if (flush_in_valid) begin
                    flush_capture = 1'b1;
                    flush_next    = PEND;
                end
            end
            PEND: begin
                flush_out_valid = (count == '0);
                if (flush_out_valid && flush_out_ready) flush_next = IDLE;
            end
            default: flush_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_cpu_req_queue.sv
// Directed bench for l2_cpu_req_queue: hand-computed checkpoints plus an address-ordered
// scoreboard that checks every head entry the L2 side accepts.
module tb_l2_cpu_req_queue;

    localparam int DEPTH     = 4;
    localparam int ADDR_BITS = 32;
    localparam int WORD_BITS = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_in_valid, req_in_ready;
    logic [1:0]           req_in_cpu_msg;
    logic [2:0]           req_in_hsize;
    logic                 req_in_hprot;
    logic [ADDR_BITS-1:0] req_in_addr;
    logic [WORD_BITS-1:0] req_in_word;
    logic [5:0]           req_in_amo;
    logic                 req_out_valid, req_out_ready;
    logic [1:0]           req_out_cpu_msg;
    logic [2:0]           req_out_hsize;
    logic                 req_out_hprot;
    logic [ADDR_BITS-1:0] req_out_addr;
    logic [WORD_BITS-1:0] req_out_word;
    logic [5:0]           req_out_amo;
    logic                 flush_in_valid, flush_in_ready, flush_in_i;
    logic                 flush_out_valid, flush_out_ready, flush_out_i;
    logic [2:0]           count;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_BITS-1:0] exp_q[$];
    int                   m_cnt;
    bit                   m_pend;

    l2_cpu_req_queue #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .WORD_BITS(WORD_BITS)) dut (
        .clk(clk), .rst(rst),
        .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
        .req_in_cpu_msg(req_in_cpu_msg), .req_in_hsize(req_in_hsize),
        .req_in_hprot(req_in_hprot), .req_in_addr(req_in_addr),
        .req_in_word(req_in_word), .req_in_amo(req_in_amo),
        .req_out_valid(req_out_valid), .req_out_ready(req_out_ready),
        .req_out_cpu_msg(req_out_cpu_msg), .req_out_hsize(req_out_hsize),
        .req_out_hprot(req_out_hprot), .req_out_addr(req_out_addr),
        .req_out_word(req_out_word), .req_out_amo(req_out_amo),
        .flush_in_valid(flush_in_valid), .flush_in_ready(flush_in_ready),
        .flush_in_i(flush_in_i),
        .flush_out_valid(flush_out_valid), .flush_out_ready(flush_out_ready),
        .flush_out_i(flush_out_i),
        .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All request fields are derived from the address so one scoreboard entry covers them.
    function automatic logic [127:0] fields_of(input logic [ADDR_BITS-1:0] a);
        return {20'd0, a[7:6], a[8:6], a[6], a, {a, ~a}, a[11:6]};
    endfunction

    task automatic set_req(input bit v, input logic [ADDR_BITS-1:0] a);
        req_in_valid   = v;
        req_in_addr    = a;
        req_in_cpu_msg = a[7:6];
        req_in_hsize   = a[8:6];
        req_in_hprot   = a[6];
        req_in_word    = {a, ~a};
        req_in_amo     = a[11:6];
    endtask

    // One clock: decide handshakes from the bench model, score pops, then advance.
    task automatic tick();
        bit push, pop;
        if (rst) begin
            m_cnt  = 0;
            m_pend = 0;
            exp_q.delete();
        end else begin
            push = req_in_valid && (m_cnt != DEPTH) && !m_pend;
            pop  = req_out_ready && (m_cnt != 0);
            if (pop) begin
                check("head_fields",
                      {20'd0, req_out_cpu_msg, req_out_hsize, req_out_hprot,
                       req_out_addr, req_out_word, req_out_amo},
                      fields_of(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (push) exp_q.push_back(req_in_addr);
            if (!m_pend && flush_in_valid) m_pend = 1;
            else if (m_pend && m_cnt == 0 && flush_out_ready) m_pend = 0;
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, '0);
        req_out_ready   = 1'b0;
        flush_in_valid  = 1'b0;
        flush_in_i      = 1'b0;
        flush_out_ready = 1'b0;
        ticks(2);
        rst = 1'b0;

        check("rst_count", count, 0);
        check("rst_out_valid", req_out_valid, 0);
        check("rst_flush_out_valid", flush_out_valid, 0);
        check("rst_flush_in_ready", flush_in_ready, 1);
        check("rst_in_ready", req_in_ready, 1);

        // fill to DEPTH with the L2 stalled
        set_req(1, 32'h100);
        tick();
        check("lat_out_valid", req_out_valid, 1);
        check("lat_head", req_out_addr, 32'h100);
        for (int i = 1; i < 4; i++) begin
            set_req(1, 32'h100 + 32'(i) * 32'h40);
            tick();
        end
        check("full_count", count, 4);
        check("full_in_ready", req_in_ready, 0);
        check("full_head", req_out_addr, 32'h100);

        // pop from full while a request waits: no push in the pop cycle
        set_req(1, 32'h200);
        req_out_ready = 1'b1;
        tick();
        check("full_pop_count", count, 3);
        check("full_pop_in_ready", req_in_ready, 1);
        req_out_ready = 1'b0;
        tick();
        check("refill_count", count, 4);
        set_req(0, '0);
        req_out_ready = 1'b1;
        ticks(4);
        check("drain_count", count, 0);

        // empty queue, consecutive pushes with L2 always ready
        set_req(1, 32'hA0);
        tick();
        check("fwft_a0_count", count, 1);
        check("fwft_a0_head", req_out_addr, 32'hA0);
        set_req(1, 32'hB0);
        tick();
        check("fwft_b0_count", count, 1);
        check("fwft_b0_head", req_out_addr, 32'hB0);
        set_req(0, '0);
        tick();
        check("fwft_empty_count", count, 0);

        // steady push+pop at count 2 across pointer wrap
        req_out_ready = 1'b0;
        set_req(1, 32'h300); tick();
        set_req(1, 32'h340); tick();
        req_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(1, 32'h380 + 32'(i) * 32'h40);
            tick();
            check("steady_count", count, 2);
        end
        set_req(0, '0);
        ticks(2);
        check("steady_drain_count", count, 0);

        // flush waits behind two older requests and blocks new ones
        req_out_ready = 1'b0;
        set_req(1, 32'h400); tick();
        set_req(1, 32'h440); tick();
        set_req(0, '0);
        flush_in_valid = 1'b1;
        flush_in_i     = 1'b1;
        tick();
        flush_in_valid = 1'b0;
        check("pend_flush_out_valid", flush_out_valid, 0);
        check("pend_flush_in_ready", flush_in_ready, 0);
        check("pend_in_ready", req_in_ready, 0);
        check("pend_count", count, 2);
        set_req(1, 32'h480);
        req_out_ready = 1'b1;
        tick();
        check("pend_one_left_flush", flush_out_valid, 0);
        check("pend_one_left_count", count, 1);
        tick();
        check("drained_flush_valid", flush_out_valid, 1);
        check("drained_flush_type", flush_out_i, 1);
        check("drained_in_ready", req_in_ready, 0);
        tick();
        check("held_flush_valid", flush_out_valid, 1);
        check("held_count", count, 0);
        flush_out_ready = 1'b1;
        tick();
        flush_out_ready = 1'b0;
        check("accept_flush_valid", flush_out_valid, 0);
        check("accept_flush_in_ready", flush_in_ready, 1);
        check("accept_in_ready", req_in_ready, 1);
        tick();
        check("post_flush_push_count", count, 1);
        set_req(0, '0);
        tick();
        check("post_flush_drain", count, 0);

        // push and flush capture in the same cycle; data-only flush type
        req_out_ready = 1'b0;
        set_req(1, 32'h500);
        flush_in_valid = 1'b1;
        flush_in_i     = 1'b0;
        tick();
        set_req(0, '0);
        flush_in_valid = 1'b0;
        check("same_cycle_count", count, 1);
        check("same_cycle_flush_valid", flush_out_valid, 0);
        req_out_ready = 1'b1;
        tick();
        check("same_cycle_flush_after", flush_out_valid, 1);
        check("same_cycle_flush_type", flush_out_i, 0);
        flush_out_ready = 1'b1;
        tick();
        flush_out_ready = 1'b0;
        check("same_cycle_idle", flush_in_ready, 1);

        // reset with three queued requests and a pending flush
        req_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 32'h600 + 32'(i) * 32'h40);
            tick();
        end
        set_req(0, '0);
        flush_in_valid = 1'b1;
        flush_in_i     = 1'b1;
        tick();
        flush_in_valid = 1'b0;
        check("pre_rst_count", count, 3);
        check("pre_rst_flush_in_ready", flush_in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_out_valid", req_out_valid, 0);
        check("mid_rst_flush_out_valid", flush_out_valid, 0);
        check("mid_rst_flush_in_ready", flush_in_ready, 1);
        check("mid_rst_in_ready", req_in_ready, 1);
        set_req(1, 32'h700);
        tick();
        set_req(0, '0);
        check("post_rst_head", req_out_addr, 32'h700);
        check("post_rst_count", count, 1);
        req_out_ready = 1'b1;
        tick();
        check("post_rst_drain", count, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
